// File: rtl/stream_seq_pkg.sv
// rtl/stream_seq_pkg.sv - shared state encoding and default widths for the stream sequence checker
package stream_seq_pkg;

   // Checker FSM: IDLE between bursts, RUN while beats are arriving back to back
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } seq_state_e;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 32;
   localparam int DEF_CNT_WIDTH  = 32;

endpackage

// File: rtl/seq_cmp.sv
// rtl/seq_cmp.sv - expected address/data tracking and per-beat compare, emits a mismatch pulse
module seq_cmp
   import stream_seq_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  sys_rst_n,
   input  logic                  beat_i,
   input  logic                  clr_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  mismatch_o
);

   logic [ADDR_WIDTH-1:0] exp_addr_q, exp_addr_d;
   logic [DATA_WIDTH-1:0] exp_data_q, exp_data_d;

   // Next expectation follows the received beat (not the old expectation), so one
   // skipped value costs a single error; any non-beat cycle returns to the burst start of 0.
   always_comb begin
      exp_addr_d = '0;
      exp_data_d = '0;
      if (!clr_i && beat_i) begin
         exp_addr_d = addr_i + ADDR_WIDTH'(1);
         exp_data_d = data_i + DATA_WIDTH'(1);
      end
   end

   // Expectation registers
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         exp_addr_q <= '0;
         exp_data_q <= '0;
      end else begin
         exp_addr_q <= exp_addr_d;
         exp_data_q <= exp_data_d;
      end
   end

   // A beat discarded by clr never counts as a mismatch
   always_comb begin
      mismatch_o = beat_i && !clr_i &&
                   ((addr_i != exp_addr_q) || (data_i != exp_data_q));
   end

endmodule

// File: rtl/stream_seq_checker.sv
// rtl/stream_seq_checker.sv - burst sequence checker top; optional error capture via SEQ_CHK_ERR_CAPTURE_EN
module stream_seq_checker
   import stream_seq_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
   input  logic                  clk,
   input  logic                  sys_rst_n,
   input  logic                  valid_in,
   input  logic [ADDR_WIDTH-1:0] addr_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  clr,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  beat_cnt,
   output logic [CNT_WIDTH-1:0]  burst_cnt,
   output logic [CNT_WIDTH-1:0]  err_cnt,
   output logic                  err_flag,
   output logic [ADDR_WIDTH-1:0] err_addr_cap,
   output logic [DATA_WIDTH-1:0] err_data_cap
);

   seq_state_e           state_q, state_d;
   logic                 burst_done;
   logic                 mismatch;
   logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
   logic [CNT_WIDTH-1:0] burst_cnt_q, burst_cnt_d;
   logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
   logic                 err_flag_q, err_flag_d;

   seq_cmp #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_seq_cmp (
      .clk        (clk),
      .sys_rst_n  (sys_rst_n),
      .beat_i     (valid_in),
      .clr_i      (clr),
      .addr_i     (addr_in),
      .data_i     (data_in),
      .mismatch_o (mismatch)
   );

   // FSM next state; a burst completes on the first idle cycle after RUN
   always_comb begin
      state_d    = state_q;
      burst_done = 1'b0;
      if (clr) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (valid_in) state_d = ST_RUN;
            ST_RUN: begin
               if (!valid_in) begin
                  state_d    = ST_IDLE;
                  burst_done = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State register
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state_q <= ST_IDLE;
      else            state_q <= state_d;
   end

   // Counter/flag next values: beat and burst counts wrap, error count saturates
   always_comb begin
      beat_cnt_d  = beat_cnt_q;
      burst_cnt_d = burst_cnt_q;
      err_cnt_d   = err_cnt_q;
      err_flag_d  = err_flag_q;
      if (clr) begin
         beat_cnt_d  = '0;
         burst_cnt_d = '0;
         err_cnt_d   = '0;
         err_flag_d  = 1'b0;
      end else begin
         if (valid_in)   beat_cnt_d  = beat_cnt_q + CNT_WIDTH'(1);
         if (burst_done) burst_cnt_d = burst_cnt_q + CNT_WIDTH'(1);
         if (mismatch) begin
            err_flag_d = 1'b1;
            if (err_cnt_q != {CNT_WIDTH{1'b1}}) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
         end
      end
   end

   // Counter/flag registers
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         beat_cnt_q  <= '0;
         burst_cnt_q <= '0;
         err_cnt_q   <= '0;
         err_flag_q  <= 1'b0;
      end else begin
         beat_cnt_q  <= beat_cnt_d;
         burst_cnt_q <= burst_cnt_d;
         err_cnt_q   <= err_cnt_d;
         err_flag_q  <= err_flag_d;
      end
   end

   assign busy      = (state_q == ST_RUN);
   assign beat_cnt  = beat_cnt_q;
   assign burst_cnt = burst_cnt_q;
   assign err_cnt   = err_cnt_q;
   assign err_flag  = err_flag_q;

`ifdef SEQ_CHK_ERR_CAPTURE_EN
   logic [ADDR_WIDTH-1:0] cap_addr_q, cap_addr_d;
   logic [DATA_WIDTH-1:0] cap_data_q, cap_data_d;

   // Capture only the mismatch that first raises err_flag
   always_comb begin
      cap_addr_d = cap_addr_q;
      cap_data_d = cap_data_q;
      if (clr) begin
         cap_addr_d = '0;
         cap_data_d = '0;
      end else if (mismatch && !err_flag_q) begin
         cap_addr_d = addr_in;
         cap_data_d = data_in;
      end
   end

   // Capture registers
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cap_addr_q <= '0;
         cap_data_q <= '0;
      end else begin
         cap_addr_q <= cap_addr_d;
         cap_data_q <= cap_data_d;
      end
   end

   assign err_addr_cap = cap_addr_q;
   assign err_data_cap = cap_data_q;
`else
   assign err_addr_cap = '0;
   assign err_data_cap = '0;
`endif

endmodule

// File: tb/tb_stream_seq_checker.sv
// tb/tb_stream_seq_checker.sv - randomized and directed self-checking bench for stream_seq_checker
module tb_stream_seq_checker;

`ifdef SEQ_CHK_ERR_CAPTURE_EN
   localparam bit CAP_EN = 1'b1;
`else
   localparam bit CAP_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic sys_rst_n;

   // instance 0: default widths
   logic        v0, c0;
   logic [31:0] a0, d0;
   logic        busy0, flag0;
   logic [31:0] beat0, burst0, err0, capa0, capd0;
   // instance 1: narrow widths, CNT_WIDTH=4
   logic        v1, c1;
   logic [7:0]  a1, d1;
   logic        busy1, flag1;
   logic [3:0]  beat1, burst1, err1;
   logic [7:0]  capa1, capd1;

   stream_seq_checker dut (
      .clk(clk), .sys_rst_n(sys_rst_n), .valid_in(v0), .addr_in(a0), .data_in(d0), .clr(c0),
      .busy(busy0), .beat_cnt(beat0), .burst_cnt(burst0), .err_cnt(err0), .err_flag(flag0),
      .err_addr_cap(capa0), .err_data_cap(capd0));

   stream_seq_checker #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .CNT_WIDTH(4)) dut4 (
      .clk(clk), .sys_rst_n(sys_rst_n), .valid_in(v1), .addr_in(a1), .data_in(d1), .clr(c1),
      .busy(busy1), .beat_cnt(beat1), .burst_cnt(burst1), .err_cnt(err1), .err_flag(flag1),
      .err_addr_cap(capa1), .err_data_cap(capd1));

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: a burst is a run of consecutive valid beats; beat k>0 must equal
   // the previous beat plus one, the first beat of a burst must be zero.
   int              m_vw[2] = '{32, 8};
   int              m_cw[2] = '{32, 4};
   bit              m_in_burst[2];
   longint unsigned m_prev_a[2], m_prev_d[2];
   longint unsigned m_beat[2], m_burst[2], m_err[2];
   bit              m_flag[2];
   longint unsigned m_cap_a[2], m_cap_d[2];

   function automatic longint unsigned msk(input int w);
      return (64'd1 << w) - 64'd1;
   endfunction

   task automatic model_clear(input int i);
      m_in_burst[i] = 0; m_prev_a[i] = 0; m_prev_d[i] = 0;
      m_beat[i] = 0; m_burst[i] = 0; m_err[i] = 0; m_flag[i] = 0;
      m_cap_a[i] = 0; m_cap_d[i] = 0;
   endtask

   task automatic model_step(input int i, input bit v, input longint unsigned a,
                             input longint unsigned d, input bit c);
      longint unsigned ea, ed;
      if (c) begin
         model_clear(i);
      end else if (v) begin
         ea = m_in_burst[i] ? ((m_prev_a[i] + 1) & msk(m_vw[i])) : 0;
         ed = m_in_burst[i] ? ((m_prev_d[i] + 1) & msk(m_vw[i])) : 0;
         m_beat[i] = (m_beat[i] + 1) & msk(m_cw[i]);
         if (a != ea || d != ed) begin
            if (m_err[i] < msk(m_cw[i])) m_err[i]++;
            if (!m_flag[i]) begin
               m_cap_a[i] = a;
               m_cap_d[i] = d;
            end
            m_flag[i] = 1;
         end
         m_prev_a[i] = a; m_prev_d[i] = d;
         m_in_burst[i] = 1;
      end else begin
         if (m_in_burst[i]) m_burst[i] = (m_burst[i] + 1) & msk(m_cw[i]);
         m_in_burst[i] = 0;
      end
   endtask

   task automatic check_all();
      chk("busy0",  busy0,  m_in_burst[0]);
      chk("beat0",  beat0,  m_beat[0]);
      chk("burst0", burst0, m_burst[0]);
      chk("err0",   err0,   m_err[0]);
      chk("flag0",  flag0,  m_flag[0]);
      chk("capa0",  capa0,  CAP_EN ? m_cap_a[0] : 0);
      chk("capd0",  capd0,  CAP_EN ? m_cap_d[0] : 0);
      chk("busy1",  busy1,  m_in_burst[1]);
      chk("beat1",  beat1,  m_beat[1]);
      chk("burst1", burst1, m_burst[1]);
      chk("err1",   err1,   m_err[1]);
      chk("flag1",  flag1,  m_flag[1]);
      chk("capa1",  capa1,  CAP_EN ? m_cap_a[1] : 0);
      chk("capd1",  capd1,  CAP_EN ? m_cap_d[1] : 0);
   endtask

   // one clock with the currently driven inputs; called and returns at negedge
   task automatic cyc();
      @(posedge clk);
      model_step(0, v0, a0, d0, c0);
      model_step(1, v1, a1, d1, c1);
      @(negedge clk);
      check_all();
   endtask

   task automatic beat(input logic [31:0] a, input logic [31:0] d);
      v0 = 1; a0 = a; d0 = d; c0 = 0; cyc();
   endtask

   task automatic gap();
      v0 = 0; c0 = 0; cyc();
   endtask

   task automatic do_clr();
      v0 = 0; c0 = 1; cyc(); c0 = 0;
   endtask

   logic [31:0] g_a0, g_d0;
   logic [7:0]  g_a1, g_d1;

   initial begin
      sys_rst_n = 0;
      v0 = 0; a0 = 0; d0 = 0; c0 = 0;
      v1 = 0; a1 = 0; d1 = 0; c1 = 0;
      model_clear(0); model_clear(1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy0, 0);
      chk("rst_beat", beat0, 0);
      chk("rst_err",  err0,  0);
      check_all();
      sys_rst_n = 1;

      // clean 8-beat burst
      for (int k = 0; k < 8; k++) beat(k, k);
      gap();
      chk("b8_beat", beat0, 8);
      chk("b8_burst", burst0, 1);
      chk("b8_err", err0, 0);
      chk("b8_flag", flag0, 0);

      // single skip: one error only
      do_clr();
      beat(0, 0); beat(1, 1); beat(2, 2); beat(4, 4); beat(5, 5); gap();
      chk("skip_err", err0, 1);
      chk("skip_flag", flag0, 1);
      chk("skip_cap", capa0, CAP_EN ? 4 : 0);
      chk("skip_beat", beat0, 5);

      // expectation wraps all-ones -> 0 without an error
      do_clr();
      beat(32'hFFFF_FFFE, 32'hFFFF_FFFE); beat(32'hFFFF_FFFF, 32'hFFFF_FFFF); beat(0, 0); gap();
      chk("wrap_err", err0, 1);

      // clr coincident with a beat discards it
      do_clr();
      beat(0, 0); beat(1, 1); beat(2, 2);
      v0 = 1; a0 = 3; d0 = 3; c0 = 1; cyc();
      chk("clr_beat", beat0, 0);
      chk("clr_err", err0, 0);
      chk("clr_busy", busy0, 0);
      beat(4, 4);
      chk("clr_next_err", err0, 1);
      chk("clr_next_busy", busy0, 1);
      beat(5, 5); gap();
      chk("clr_tail_err", err0, 1);

      // async reset mid-burst
      beat(0, 0); beat(1, 1); beat(2, 2);
      v0 = 1; a0 = 3; d0 = 3;
      sys_rst_n = 0;
      #1;
      chk("arst_busy", busy0, 0);
      chk("arst_beat", beat0, 0);
      chk("arst_burst", burst0, 0);
      chk("arst_err", err0, 0);
      chk("arst_flag", flag0, 0);
      model_clear(0); model_clear(1);
      @(posedge clk);
      @(negedge clk);
      check_all();
      sys_rst_n = 1;
      for (int k = 0; k < 4; k++) beat(k, k);
      gap();
      chk("post_rst_err", err0, 0);
      chk("post_rst_beat", beat0, 4);
      chk("post_rst_burst", burst0, 1);

      // saturation on the narrow instance
      for (int k = 0; k < 20; k++) begin
         v1 = 1; a1 = 8'd5; d1 = 8'd9; c1 = 0; cyc();
      end
      v1 = 0; cyc();
      chk("sat_err", err1, 15);
      chk("sat_beat", beat1, 4);
      chk("sat_cap", capa1, CAP_EN ? 5 : 0);

      // randomized traffic on both instances
      v1 = 1; c1 = 1; cyc(); c1 = 0; v1 = 0;
      g_a0 = 0; g_d0 = 0; g_a1 = 0; g_d1 = 0;
      for (int n = 0; n < 800; n++) begin
         v0 = ($urandom_range(0, 9) < 8);
         c0 = ($urandom_range(0, 49) == 0);
         a0 = ($urandom_range(0, 9) == 0) ? $urandom() : g_a0;
         d0 = ($urandom_range(0, 9) == 0) ? $urandom() : g_d0;
         v1 = ($urandom_range(0, 9) < 7);
         c1 = ($urandom_range(0, 59) == 0);
         a1 = ($urandom_range(0, 7) == 0) ? 8'($urandom()) : g_a1;
         d1 = ($urandom_range(0, 7) == 0) ? 8'($urandom()) : g_d1;
         cyc();
         g_a0 = (v0 && !c0) ? a0 + 1 : 0;
         g_d0 = (v0 && !c0) ? d0 + 1 : 0;
         g_a1 = (v1 && !c1) ? a1 + 8'd1 : 8'd0;
         g_d1 = (v1 && !c1) ? d1 + 8'd1 : 8'd0;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/stream_seq_checker.md
STREAM_SEQ_CHECKER -- requirements
Module: stream_seq_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of data_in and of the capture data register.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, width of addr_in and of the capture address register.
REQ-003 SHALL have parameter CNT_WIDTH, default 32, width of beat_cnt, burst_cnt and err_cnt.
REQ-004 SHALL have port clk  input  1  the single clock; all logic rising-edge.
REQ-005 SHALL have port sys_rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port valid_in  input  1  beat qualifier; high = addr_in/data_in valid this cycle.
REQ-007 SHALL have port addr_in  input  ADDR_WIDTH  received address.
REQ-008 SHALL have port data_in  input  DATA_WIDTH  received data.
REQ-009 SHALL have port clr  input  1  synchronous clear of counters, flags and captures.
REQ-010 SHALL have port busy  output  1  high while in RUN.
REQ-011 SHALL have port beat_cnt  output  CNT_WIDTH  valid beats accepted.
REQ-012 SHALL have port burst_cnt  output  CNT_WIDTH  completed bursts.
REQ-013 SHALL have port err_cnt  output  CNT_WIDTH  mismatching beats.
REQ-014 SHALL have port err_flag  output  1  sticky; any mismatch since reset/clr.
REQ-015 SHALL have port err_addr_cap  output  ADDR_WIDTH  addr_in of first mismatch.
REQ-016 SHALL have port err_data_cap  output  DATA_WIDTH  data_in of first mismatch.

Function
REQ-017 SHALL implement FSM states IDLE and RUN; IDLE->RUN on valid_in=1; RUN->IDLE on valid_in=0.
REQ-018 SHALL hold exp_addr/exp_data, both 0 in IDLE; each beat compares addr_in==exp_addr AND data_in==exp_data.
REQ-019 SHALL, after every beat, set exp_addr=addr_in+1 and exp_data=data_in+1 (mod 2^width, wrap all-ones->0), so a single skip counts one error, not a cascade.
REQ-020 SHALL, on RUN->IDLE, increment burst_cnt once and reset exp_addr/exp_data to 0.
REQ-021 SHALL register all outputs; counters/flags reflect a beat on the cycle after it (latency 1).
REQ-022 SHALL wrap beat_cnt and burst_cnt modulo 2^CNT_WIDTH; err_cnt SHALL saturate at all-ones.
REQ-023 SHALL set err_flag on first mismatch and hold it until clr or reset.
REQ-024 SHALL treat clr as priority over a coincident beat: the beat is discarded, state->IDLE, expectations->0, all counters/flags/captures->0.
REQ-025 SHALL continue accepting beats when valid_in stays high after clr (next cycle enters RUN, expects 0).

Reset
REQ-026 SHALL, on sys_rst_n=0 (asynchronous, any cycle incl. mid-burst), force state IDLE, busy=0, all counters, err_flag, captures and expectations to 0.
REQ-027 SHALL ignore valid_in during reset; first beat after deassertion is compared against 0.

Configuration
REQ-028 SHALL use macro SEQ_CHK_ERR_CAPTURE_EN.
REQ-029 SHALL, with macro defined, load err_addr_cap/err_data_cap on the mismatch that sets err_flag and hold them until clr/reset.
REQ-030 SHALL, without macro, keep both capture ports present and tied to 0, with no capture registers synthesized.

Structure
REQ-031 SHALL place FSM state encoding (IDLE=0, RUN=1) and default width constants in shared package stream_seq_pkg.
REQ-032 SHALL instantiate sub-module seq_cmp holding exp registers, compare and increment logic, outputting a one-bit mismatch pulse.

Verification
REQ-033 SHALL test: 8-beat burst addr/data 0..7, gap -> beat_cnt=8, burst_cnt=1, err_cnt=0, err_flag=0.
REQ-034 SHALL test: burst 0,1,2,4,5 -> err_cnt=1, err_flag=1, err_addr_cap=4 (with macro), beat_cnt=5.
REQ-035 SHALL test: beat with exp=FFFFFFFF then 0 (ADDR/DATA 32) -> no error at wrap.
REQ-036 SHALL test: clr coincident with beat 3 of burst 0..5 -> counters 0 next cycle, following beat 4 counted as error (expected 0).
REQ-037 SHALL test: sys_rst_n low mid-burst for 1 cycle -> busy=0 and all outputs 0 immediately; next burst from 0 passes clean.
REQ-038 SHALL test: CNT_WIDTH=4, 20 mismatching beats -> err_cnt=15 saturated; macro undefined -> captures read 0.
